sync_queue: RTL and testbench
=============================

Name: sync_queue

Overview:
Parametrised synchronous FIFO for the MIPS datapath; successor to the fixed 32x32 queue.
- Single clock. Width and depth are generic.
- Counter-based full/empty plus programmable almost-full/almost-empty.
- Registered read port with an explicit valid strobe.
- Defined simultaneous push/pop and wrap-around behaviour; used to buffer words between pipeline stages and peripherals.

Parameters:
DATA_W, 32, width of each stored word
DEPTH, 32, number of entries; power of two, >= 2
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  write request
writeData  input  DATA_W  word to write
pop  input  1  read request
readData  output  DATA_W  registered read word
readValid  output  1  high one cycle after an accepted pop
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst high at a rising edge):
  - wr_ptr, rd_ptr and count go to 0; readData goes to 0; readValid goes to 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0).
  - Storage array is not reset.
  - Reset mid-operation discards all contents; push/pop in the reset cycle are ignored.
- Pop acceptance: pop_ok = pop & ~empty.
- Push acceptance: push_ok = push & (~full | pop_ok).
  - A push to a full queue is accepted only when a pop is accepted in the same cycle.
- On push_ok: mem[wr_ptr] <= writeData; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
- On pop_ok: readData <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; readValid <= 1.
  - Otherwise readValid <= 0 and readData holds its previous value.
- Read latency: data appears on readData exactly one clock after the accepted pop.
- Count update: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
- Flags are combinational decodes of the count register, so they update in the same cycle count changes. No flag lags count.
- Empty + push + pop in the same cycle: pop rejected (readValid stays 0), push accepted, count becomes 1.
- Full + push + pop in the same cycle: both accepted. Oldest word is read, new word is written into the freed slot, count stays DEPTH.
- Push when full without pop: ignored; memory and pointers unchanged.
- Pop when empty: ignored; readData unchanged.
- Ordering is strictly FIFO across any number of pointer wraps.

Optional Feature:
Macro: SYNC_QUEUE_ERR_EN
- Defined:
  - Adds outputs overflow (1) and underflow (1), both sticky and cleared only by rst.
  - overflow sets on the edge after push & ~push_ok.
  - underflow sets on the edge after pop & empty.
  - Both reset to 0. Data path behaviour is unchanged.
- Not defined: ports and logic are absent. Rejected requests are silently dropped as described above.

Test Plan:
1. Reset, then idle 3 cycles -> empty=1, full=0, count=0, readValid=0, readData=0.
2. DEPTH=32: push 0x00000001..0x00000020 on consecutive cycles. Then push 0xDEADBEEF while full.
   -> full=1, count=32, almost_full from count 30. The 0xDEADBEEF push is dropped; overflow=1 if SYNC_QUEUE_ERR_EN.
3. From the case-2 state, pop 32 times.
   -> readData = 0x1..0x20 in order, each one cycle after its pop, readValid high each time. Then empty=1; a further pop gives readValid=0 and underflow=1 if enabled.
4. DEPTH=4: push 0xA, 0xB, 0xC, then push 0xD with pop in the same cycle, repeated 10 times with incrementing data.
   -> count stays 3. Output sequence is 0xA, 0xB, 0xC, 0xD, ... with no loss across pointer wrap.
5. Empty queue, push 0x55 and pop in the same cycle -> readValid=0, count=1. The next pop returns 0x55.
6. Full DEPTH=4 queue, push 0x99 + pop in the same cycle -> oldest word out, count=4, full stays 1. Assert rst mid-stream -> count=0 next cycle, all queued data lost.

Source files
------------

// File: rtl/sync_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sync_queue_if                                           |
// | Brief    : Handshake/data bundle between a producer/consumer and   |
// |            sync_queue. overflow/underflow exist only when          |
// |            SYNC_QUEUE_ERR_EN is defined.                           |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface sync_queue_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32
) ();
   logic                     push;
   logic [DATA_W-1:0]        writeData;
   logic                     pop;
   logic [DATA_W-1:0]        readData;
   logic                     readValid;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [$clog2(DEPTH):0]   count;
`ifdef SYNC_QUEUE_ERR_EN
   logic                     overflow;
   logic                     underflow;
`endif

   // Producer/consumer side
   modport master (
      output push, writeData, pop,
      input  readData, readValid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_QUEUE_ERR_EN
      , input overflow, underflow
`endif
   );

   // Queue side
   modport slave (
      input  push, writeData, pop,
      output readData, readValid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_QUEUE_ERR_EN
      , output overflow, underflow
`endif
   );
endinterface
`default_nettype wire

// File: rtl/sync_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sync_queue                                              |
// | Brief    : Parametrised single-clock FIFO with counter-based       |
// |            full/empty, programmable almost flags and a registered  |
// |            read port with valid strobe.                            |
// |            Optional sticky overflow/underflow: SYNC_QUEUE_ERR_EN.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module sync_queue #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 32,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   sync_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage is deliberately left out of reset
   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              is_empty, is_full;
   logic              pop_ok, push_ok;

   // Flags decode the count register directly so none of them lags count
   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == CW'(DEPTH));
      pop_ok   = q.pop & ~is_empty;
      // A full queue still takes a word when a pop frees a slot this cycle
      push_ok  = q.push & (~is_full | pop_ok);
   end

   // Next-state for pointers, occupancy and the registered read port
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      read_data_d  = read_data_q;
      read_valid_d = pop_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         read_data_d = mem[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards contents and ignores that cycle's requests
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
      end
   end

   // Storage write; pointers wrap naturally so the freed slot is reused
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr_q] <= q.writeData;
   end

   assign q.readData     = read_data_q;
   assign q.readValid    = read_valid_q;
   assign q.count        = count_q;
   assign q.empty        = is_empty;
   assign q.full         = is_full;
   assign q.almost_full  = (int'(count_q) >= AFULL_TH);
   assign q.almost_empty = (int'(count_q) <= AEMPTY_TH);

`ifdef SYNC_QUEUE_ERR_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags, cleared only by reset
   always_comb begin
      overflow_d  = overflow_q  | (q.push & ~push_ok);
      underflow_d = underflow_q | (q.pop & is_empty);
   end

   // Error flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign q.overflow  = overflow_q;
   assign q.underflow = underflow_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sync_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_sync_queue                                           |
// | Brief    : Directed self-checking bench for sync_queue, one        |
// |            32-deep and one 4-deep instance. Error flags checked    |
// |            when SYNC_QUEUE_ERR_EN is defined.                      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_sync_queue;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sync_queue_if #(.DATA_W(32), .DEPTH(32)) b32 ();
   sync_queue_if #(.DATA_W(32), .DEPTH(4))  b4 ();

   sync_queue #(.DATA_W(32), .DEPTH(32), .AFULL_TH(30), .AEMPTY_TH(2)) u_q32 (
      .clk(clk), .rst(rst), .q(b32));
   sync_queue #(.DATA_W(32), .DEPTH(4), .AFULL_TH(2), .AEMPTY_TH(1)) u_q4 (
      .clk(clk), .rst(rst), .q(b4));

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b32.push = 1'b0; b32.pop = 1'b0; b32.writeData = '0;
      b4.push  = 1'b0; b4.pop  = 1'b0; b4.writeData  = '0;
   endtask

   task automatic test_reset();
      idle_all();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      total++; if (b32.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", b32.empty); end
      total++; if (b32.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", b32.full); end
      total++; if (b32.count !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", b32.count); end
      total++; if (b32.readValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", b32.readValid); end
      total++; if (b32.readData !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", b32.readData); end
      total++; if (b32.almost_empty !== 1'b1) begin bad++; $display("FAIL rst_aempty got=%b exp=1", b32.almost_empty); end
      total++; if (b32.almost_full !== 1'b0) begin bad++; $display("FAIL rst_afull got=%b exp=0", b32.almost_full); end
      total++; if (b4.empty !== 1'b1 || b4.count !== 3'd0) begin bad++; $display("FAIL rst4 got=%b/%0d exp=1/0", b4.empty, b4.count); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b32.overflow !== 1'b0 || b32.underflow !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", b32.overflow, b32.underflow); end
`endif
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 32; i++) begin
         b32.push = 1'b1; b32.writeData = 32'(i);
         tick();
         total++; if (b32.count !== 6'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, b32.count, i); end
         total++; if (b32.almost_full !== (i >= 30)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, b32.almost_full, (i >= 30)); end
         total++; if (b32.full !== (i == 32)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, b32.full, (i == 32)); end
         total++; if (b32.almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, b32.almost_empty, (i <= 2)); end
      end
      b32.writeData = 32'hDEADBEEF;
      tick();
      b32.push = 1'b0;
      total++; if (b32.count !== 6'd32) begin bad++; $display("FAIL ovf_count got=%0d exp=32", b32.count); end
      total++; if (b32.full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", b32.full); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b32.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", b32.overflow); end
`endif
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 32; i++) begin
         b32.pop = 1'b1;
         tick();
         total++; if (b32.readValid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, b32.readValid); end
         total++; if (b32.readData !== 32'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, b32.readData, 32'(i)); end
         total++; if (b32.count !== 6'(32 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, b32.count, 32 - i); end
      end
      total++; if (b32.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", b32.empty); end
      tick();
      b32.pop = 1'b0;
      total++; if (b32.readValid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b exp=0", b32.readValid); end
      total++; if (b32.readData !== 32'h20) begin bad++; $display("FAIL udf_hold got=%h exp=00000020", b32.readData); end
      total++; if (b32.count !== 6'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", b32.count); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b32.underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", b32.underflow); end
`endif
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         b4.push = 1'b1; b4.writeData = 32'hA + 32'(i);
         tick();
      end
      total++; if (b4.count !== 3'd3) begin bad++; $display("FAIL wrap_pre_count got=%0d exp=3", b4.count); end
      for (int k = 0; k < 10; k++) begin
         b4.push = 1'b1; b4.pop = 1'b1; b4.writeData = 32'hD + 32'(k);
         tick();
         total++; if (b4.count !== 3'd3) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=3", k, b4.count); end
         total++; if (b4.readValid !== 1'b1 || b4.readData !== 32'hA + 32'(k)) begin bad++; $display("FAIL wrap_data[%0d] got=%b/%h exp=1/%h", k, b4.readValid, b4.readData, 32'hA + 32'(k)); end
      end
      b4.push = 1'b0;
      for (int k = 10; k < 13; k++) begin
         b4.pop = 1'b1;
         tick();
         total++; if (b4.readData !== 32'hA + 32'(k)) begin bad++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", k, b4.readData, 32'hA + 32'(k)); end
      end
      b4.pop = 1'b0;
      total++; if (b4.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", b4.empty); end
   endtask

   task automatic test_empty_pushpop();
      b4.push = 1'b1; b4.pop = 1'b1; b4.writeData = 32'h55;
      tick();
      b4.push = 1'b0;
      total++; if (b4.readValid !== 1'b0) begin bad++; $display("FAIL epp_valid got=%b exp=0", b4.readValid); end
      total++; if (b4.count !== 3'd1) begin bad++; $display("FAIL epp_count got=%0d exp=1", b4.count); end
      total++; if (b4.readData !== 32'h16) begin bad++; $display("FAIL epp_hold got=%h exp=00000016", b4.readData); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b4.underflow !== 1'b1) begin bad++; $display("FAIL epp_udf got=%b exp=1", b4.underflow); end
`endif
      tick();
      b4.pop = 1'b0;
      total++; if (b4.readValid !== 1'b1 || b4.readData !== 32'h55) begin bad++; $display("FAIL epp_data got=%b/%h exp=1/00000055", b4.readValid, b4.readData); end
      total++; if (b4.count !== 3'd0) begin bad++; $display("FAIL epp_count2 got=%0d exp=0", b4.count); end
   endtask

   task automatic test_full_pushpop();
      for (int i = 1; i <= 4; i++) begin
         b4.push = 1'b1; b4.writeData = 32'(i);
         tick();
      end
      total++; if (b4.full !== 1'b1 || b4.count !== 3'd4) begin bad++; $display("FAIL fpp_pre got=%b/%0d exp=1/4", b4.full, b4.count); end
      b4.pop = 1'b1; b4.writeData = 32'h99;
      tick();
      b4.push = 1'b0;
      total++; if (b4.readValid !== 1'b1 || b4.readData !== 32'h1) begin bad++; $display("FAIL fpp_data got=%b/%h exp=1/00000001", b4.readValid, b4.readData); end
      total++; if (b4.count !== 3'd4 || b4.full !== 1'b1) begin bad++; $display("FAIL fpp_count got=%0d/%b exp=4/1", b4.count, b4.full); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b4.overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", b4.overflow); end
`endif
      tick();
      total++; if (b4.readData !== 32'h2 || b4.count !== 3'd3) begin bad++; $display("FAIL fpp_next got=%h/%0d exp=00000002/3", b4.readData, b4.count); end
      // Reset mid-stream with requests pending: they must be ignored
      rst = 1'b1; b4.push = 1'b1; b4.pop = 1'b1; b4.writeData = 32'h77;
      tick();
      rst = 1'b0; b4.push = 1'b0;
      total++; if (b4.count !== 3'd0 || b4.empty !== 1'b1) begin bad++; $display("FAIL mrst_count got=%0d/%b exp=0/1", b4.count, b4.empty); end
      total++; if (b4.readValid !== 1'b0 || b4.readData !== 32'h0) begin bad++; $display("FAIL mrst_port got=%b/%h exp=0/00000000", b4.readValid, b4.readData); end
`ifdef SYNC_QUEUE_ERR_EN
      total++; if (b4.underflow !== 1'b0) begin bad++; $display("FAIL mrst_udf got=%b exp=0", b4.underflow); end
`endif
      tick();
      b4.pop = 1'b0;
      total++; if (b4.readValid !== 1'b0 || b4.count !== 3'd0) begin bad++; $display("FAIL mrst_lost got=%b/%0d exp=0/0", b4.readValid, b4.count); end
      b4.push = 1'b1; b4.writeData = 32'h42;
      tick();
      b4.push = 1'b0; b4.pop = 1'b1;
      tick();
      b4.pop = 1'b0;
      total++; if (b4.readValid !== 1'b1 || b4.readData !== 32'h42) begin bad++; $display("FAIL mrst_after got=%b/%h exp=1/00000042", b4.readValid, b4.readData); end
   endtask

   initial begin
      idle_all();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_empty_pushpop();
      test_full_pushpop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
